// File: rtl/operand_fetch.sv
// Streams 64-bit operand pairs (SRAM_A upper, SRAM_B lower) over an address range onto a valid/ready port.
// Start-to-first-valid 3 cycles, 1 pair/cycle; a 2-entry skid FIFO absorbs the read latency so reads stall only when it would overflow.
module operand_fetch #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] read_start_addr,
  input  logic [ADDR_W-1:0] read_end_addr,
  output logic              csb1_o,
  output logic [ADDR_W-1:0] addr1_o,
  input  logic [DATA_W-1:0] r_data_a_i,
  input  logic [DATA_W-1:0] r_data_b_i,
  output logic              op_valid_o,
  input  logic              op_ready_i,
  output logic [DATA_W-1:0] op_a_o,
  output logic [DATA_W-1:0] op_b_o,
  output logic [ADDR_W-1:0] op_addr_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_e;

  state_e                      state_q;
  logic [ADDR_W-1:0]           cur_q;
  logic [ADDR_W:0]             rem_q;
  logic [ADDR_W-1:0]           addr1_q;
  logic                        inflight_q;
  logic [ADDR_W-1:0]           inflight_addr_q;
  logic [1:0]                  count_q;
  logic                        rd_ptr_q;
  logic                        wr_ptr_q;
  logic [1:0][DATA_W-1:0]      fa_q;
  logic [1:0][DATA_W-1:0]      fb_q;
  logic [1:0][ADDR_W-1:0]      fadr_q;

  logic       pop;
  logic       issue;
  logic       drained;
  logic [2:0] occ;

  // occ is what the FIFO will hold once everything outstanding lands, net of this cycle's pop
  assign pop     = (count_q != 2'd0) & op_ready_i;
  assign occ     = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue   = (state_q == FETCH) & (rem_q != '0) & (occ < 3'(FIFO_DEPTH));
  assign drained = ~inflight_q & ((count_q == 2'd0) | ((count_q == 2'd1) & pop));

  assign csb1_o     = ~issue;
  assign addr1_o    = issue ? cur_q : addr1_q;
  assign op_valid_o = (count_q != 2'd0);
  assign op_a_o     = fa_q[rd_ptr_q];
  assign op_b_o     = fb_q[rd_ptr_q];
  assign op_addr_o  = fadr_q[rd_ptr_q];
  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == DONE);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q         <= IDLE;
      cur_q           <= '0;
      rem_q           <= '0;
      addr1_q         <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      count_q         <= 2'd0;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      fa_q            <= '0;
      fb_q            <= '0;
      fadr_q          <= '0;
    end else begin
      addr1_q    <= addr1_o;
      inflight_q <= issue;
      if (issue) inflight_addr_q <= cur_q;

      if (inflight_q) begin
        fa_q[wr_ptr_q]   <= r_data_a_i;
        fb_q[wr_ptr_q]   <= r_data_b_i;
        fadr_q[wr_ptr_q] <= inflight_addr_q;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, inflight_q} - {1'b0, pop};

      case (state_q)
        IDLE: begin
          if (start_i) begin
            cur_q   <= read_start_addr;
            rem_q   <= {1'b0, read_end_addr - read_start_addr} + (ADDR_W+1)'(1);
            state_q <= FETCH;
          end
        end
        FETCH: begin
          if (issue) begin
            cur_q <= cur_q + ADDR_W'(1);
            rem_q <= rem_q - (ADDR_W+1)'(1);
            if (rem_q == (ADDR_W+1)'(1)) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (drained) state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed + randomized bench for operand_fetch: behavioural SRAMs, expected address/data queues per pass.
module tb_operand_fetch;
  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [AW-1:0] read_start_addr;
  logic [AW-1:0] read_end_addr;
  logic          csb1_o;
  logic [AW-1:0] addr1_o;
  logic [DW-1:0] r_data_a_i;
  logic [DW-1:0] r_data_b_i;
  logic          op_valid_o;
  logic          op_ready_i;
  logic [DW-1:0] op_a_o;
  logic [DW-1:0] op_b_o;
  logic [AW-1:0] op_addr_o;
  logic          busy_o;
  logic          done_o;

  always #5 clk_i = ~clk_i;

  operand_fetch #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .read_start_addr(read_start_addr), .read_end_addr(read_end_addr),
    .csb1_o(csb1_o), .addr1_o(addr1_o),
    .r_data_a_i(r_data_a_i), .r_data_b_i(r_data_b_i),
    .op_valid_o(op_valid_o), .op_ready_i(op_ready_i),
    .op_a_o(op_a_o), .op_b_o(op_b_o), .op_addr_o(op_addr_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  logic [DW-1:0] mem_a [512];
  logic [DW-1:0] mem_b [512];

  // Synchronous-read SRAM pair: data for a read enabled at edge N is visible during cycle N+1
  always @(posedge clk_i) begin
    if (!csb1_o) begin
      r_data_a_i <= mem_a[addr1_o];
      r_data_b_i <= mem_b[addr1_o];
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_csb"},   64'(csb1_o),     64'd1);
    check({tag, "_addr"},  64'(addr1_o),    64'd0);
    check({tag, "_vld"},   64'(op_valid_o), 64'd0);
    check({tag, "_opa"},   64'(op_a_o),     64'd0);
    check({tag, "_opb"},   64'(op_b_o),     64'd0);
    check({tag, "_opadr"}, 64'(op_addr_o),  64'd0);
    check({tag, "_busy"},  64'(busy_o),     64'd0);
    check({tag, "_done"},  64'(done_o),     64'd0);
  endtask

  // mode: 0 ready always high, 1 ready pattern 1,0,0, 2 random ready
  task automatic run_pass(input logic [AW-1:0] s, input logic [AW-1:0] e, input int mode, input bit restart);
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] iss_q[$];
    logic [AW-1:0] ea;
    logic [AW-1:0] prev_addr;
    logic [63:0]   prev_pair;
    int  n;
    int  issued = 0;
    int  popped = 0;
    int  first_v = -1;
    int  last_pop = -1;
    int  done_cyc = -1;
    bit  prev_stall = 1'b0;
    bit  pop;
    n = ((int'(e) - int'(s)) & 511) + 1;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(AW'(int'(s) + i));
      iss_q.push_back(AW'(int'(s) + i));
    end
    for (int cyc = 0; cyc < 400 && done_cyc < 0; cyc++) begin
      @(negedge clk_i);
      start_i         = (cyc == 0) || (restart && cyc == 2);
      read_start_addr = (cyc == 0) ? s : s + 9'd37;
      read_end_addr   = (cyc == 0) ? e : e + 9'd5;
      case (mode)
        0:       op_ready_i = 1'b1;
        1:       op_ready_i = (cyc % 3 == 0);
        default: op_ready_i = 1'($urandom_range(0, 1));
      endcase
      #1;
      pop = op_valid_o && op_ready_i;
      if (op_valid_o && first_v < 0) first_v = cyc;
      if (!csb1_o) begin
        check("rd_within_range", 64'(issued < n), 64'd1);
        check("rd_no_overflow", 64'((issued - popped - int'(pop)) < 2), 64'd1);
        if (iss_q.size() > 0) check("rd_addr", 64'(addr1_o), 64'(iss_q.pop_front()));
        issued++;
      end
      if (prev_stall) begin
        check("stall_vld",  64'(op_valid_o), 64'd1);
        check("stall_pair", {op_a_o, op_b_o}, prev_pair);
        check("stall_addr", 64'(op_addr_o), 64'(prev_addr));
      end
      if (pop) begin
        check("pop_within_range", 64'(popped < n), 64'd1);
        if (exp_q.size() > 0) begin
          ea = exp_q.pop_front();
          check("pop_addr", 64'(op_addr_o), 64'(ea));
          check("pop_pair", {op_a_o, op_b_o}, {mem_a[ea], mem_b[ea]});
        end
        popped++;
        last_pop = cyc;
      end
      prev_stall = op_valid_o && !op_ready_i;
      prev_pair  = {op_a_o, op_b_o};
      prev_addr  = op_addr_o;
      if (done_o) done_cyc = cyc;
    end
    start_i = 1'b0;
    check("done_seen", 64'(done_cyc >= 0), 64'd1);
    check("pop_count", 64'(popped), 64'(n));
    check("done_after_last_pop", 64'(done_cyc), 64'(last_pop + 1));
    if (mode == 0) begin
      check("first_valid_latency", 64'(first_v), 64'd3);
      check("back_to_back", 64'(last_pop - first_v), 64'(n - 1));
    end
    @(negedge clk_i);
    op_ready_i = 1'b1;
    #1;
    check("done_single_pulse", 64'(done_o), 64'd0);
    check("idle_after_done",   64'(busy_o), 64'd0);
    check("no_stale_valid",    64'(op_valid_o), 64'd0);
  endtask

  initial begin
    logic [AW-1:0] rs;
    rst_i = 1'b0;
    start_i = 1'b0;
    op_ready_i = 1'b0;
    read_start_addr = '0;
    read_end_addr = '0;
    for (int i = 0; i < 512; i++) begin
      mem_a[i] = $urandom;
      mem_b[i] = $urandom;
    end
    for (int i = 0; i < 4; i++) begin
      mem_a[i] = DW'(i);
      mem_b[i] = DW'(100 + i);
    end
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    #1;
    check_reset_outputs("por");
    rst_i = 1'b1;

    // Reset asserted mid-pass while a read is outstanding
    @(negedge clk_i);
    start_i = 1'b1;
    read_start_addr = 9'd20;
    read_end_addr = 9'd30;
    @(negedge clk_i);
    start_i = 1'b0;
    #1;
    check("pre_reset_issue", 64'(csb1_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check_reset_outputs("midpass");
    @(negedge clk_i);
    rst_i = 1'b1;
    op_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      #1;
      check("post_reset_vld", 64'(op_valid_o), 64'd0);
      check("post_reset_csb", 64'(csb1_o), 64'd1);
    end

    run_pass(9'd0, 9'd3, 0, 1'b0);
    run_pass(9'd0, 9'd3, 1, 1'b0);
    run_pass(9'd510, 9'd1, 0, 1'b0);
    run_pass(9'd510, 9'd1, 1, 1'b0);
    run_pass(9'd7, 9'd7, 0, 1'b0);
    run_pass(9'd7, 9'd7, 1, 1'b0);
    run_pass(9'd40, 9'd60, 1, 1'b1);
    run_pass(9'd40, 9'd60, 0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      rs = AW'($urandom_range(0, 511));
      run_pass(rs, rs + AW'($urandom_range(0, 20)), 2, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
